// File: rtl/sincos_pkg.sv
// Shared types, constants and angle helpers for the sin/cos arbiter.
// Angles are signed fixed point with 256 = 1.0 rad; PI is approximated by 804.
package sincos_pkg;

  localparam int ANGLE_W  = 27;
  // Tag id field is sized for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  localparam logic signed [ANGLE_W-1:0] HALF_PI = 27'sd402;
  localparam logic signed [ANGLE_W-1:0] PI      = 27'sd804;
  localparam logic signed [ANGLE_W-1:0] TWO_PI  = 27'sd1608;

  typedef enum logic {
    OP_SIN = 1'b0,
    OP_COS = 1'b1
  } sincos_op_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } sincos_tag_t;

  // One wrap step that pulls an angle from [-3*PI, 3*PI] into [-PI, PI].
  function automatic logic signed [ANGLE_W-1:0] reduce_angle(input logic signed [ANGLE_W-1:0] a);
    logic signed [ANGLE_W-1:0] r;
    if (a > PI) begin
      r = a - TWO_PI;
    end else if (a < -PI) begin
      r = a + TWO_PI;
    end else begin
      r = a;
    end
    return r;
  endfunction

  // cos(a) = sin(a + PI/2), wrapped back into [-PI, PI].
  function automatic logic signed [ANGLE_W-1:0] cos_shift(input logic signed [ANGLE_W-1:0] a);
    logic signed [ANGLE_W-1:0] r;
    r = a + HALF_PI;
    if (r > PI) begin
      r = r - TWO_PI;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/sincos_arbiter_if.sv
// Request/response bus between the requesters and sincos_arbiter.
// master = requester side, slave = arbiter side.
interface sincos_arbiter_if #(
  parameter int NREQ = 4
) ();
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]                       req_valid;
  logic [NREQ-1:0]                       req_op;
  logic [NREQ*sincos_pkg::ANGLE_W-1:0]   req_angle;
  logic [NREQ-1:0]                       req_ready;
  logic                                  rsp_valid;
  logic [ID_W-1:0]                       rsp_id;
  logic signed [sincos_pkg::ANGLE_W-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_angle,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_angle,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/sincos_arbiter_chk.sv
// Input-range checker used when the arbiter is built without angle
// reduction: every accepted angle must already be inside [-PI, PI].
module sincos_arbiter_chk
  import sincos_pkg::*;
(
  input logic                      clk_i,
  input logic                      reset_i,
  input logic                      accept_i,
  input logic signed [ANGLE_W-1:0] angle_i
);

  property p_angle_in_range;
    @(posedge clk_i) disable iff (reset_i)
      accept_i |-> ((angle_i <= PI) && (angle_i >= -PI));
  endproperty

  a_angle_in_range: assert property (p_angle_in_range)
    else $error("sincos_arbiter: accepted angle %0d outside [-804, 804]", angle_i);

endmodule

// File: rtl/sincos_tag_pipe.sv
// Shift register of {valid, id} tags that tracks ops in flight through the
// sin unit. It advances only on enabled cycles so it stays aligned with the
// sin unit, which is frozen by the same enable.
module sincos_tag_pipe
  import sincos_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  sincos_tag_t tag_i,
  output sincos_tag_t tag_o,
  output logic        any_valid_o
);

  sincos_tag_t pipe_q [DEPTH];
  sincos_tag_t pipe_d [DEPTH];

  // Next-state: shift one stage on enabled cycles, hold otherwise.
  always_comb begin
    pipe_d = pipe_q;
    if (en_i) begin
      pipe_d[0] = tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end else begin
      pipe_d = pipe_q;
    end
  end

  // Stage registers; reset empties the pipe so dropped ops never respond.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Any stage holding a live op.
  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid_o = any_valid_o | pipe_q[i].valid;
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sincos_arbiter.sv
// Shares one pipelined sin unit among NREQ requesters with a round-robin
// grant. COS ops are issued as sin(angle + PI/2). An en-gated tag pipe routes
// each sin result back to the requester that issued it.
// Optional build macro: SINCOS_RANGE_REDUCE_EN -- when defined, input angles
// in [-3*PI, 3*PI] get one wrap step before the COS offset; when undefined,
// inputs must already be in [-PI, PI] and a checker flags violations.
module sincos_arbiter
  import sincos_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int SIN_LATENCY = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      en_i,
  sincos_arbiter_if.slave           bus,
  output logic                      sin_en_o,
  output logic signed [ANGLE_W-1:0] sin_angle_o,
  input  logic signed [ANGLE_W-1:0] sin_result_i,
  output logic                      busy_o
);

  localparam int ID_W = $clog2(NREQ);

  logic [ID_W-1:0]           ptr_q, ptr_d;
  logic [NREQ-1:0]           grant_s;
  logic [ID_W-1:0]           winner_s;
  logic                      accept_s;
  logic signed [ANGLE_W-1:0] sel_angle_s;
  sincos_op_t                sel_op_s;
  logic signed [ANGLE_W-1:0] base_angle_s;
  logic signed [ANGLE_W-1:0] mapped_angle_s;
  sincos_tag_t               tag_in_s;
  sincos_tag_t               tag_last_s;
  logic                      tag_busy_s;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]           rsp_id_q, rsp_id_d;
  logic signed [ANGLE_W-1:0] rsp_data_q, rsp_data_d;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    logic [ID_W:0]   idx_wide;
    logic [ID_W-1:0] idx;
    logic            found;
    logic            hit;
    grant_s  = '0;
    winner_s = '0;
    found    = 1'b0;
    idx_wide = '0;
    idx      = '0;
    hit      = 1'b0;
    if (en_i && !reset_i) begin
      for (int i = 0; i < NREQ; i++) begin
        idx_wide = {1'b0, ptr_q} + (ID_W+1)'(i);
        idx_wide = (idx_wide >= (ID_W+1)'(NREQ)) ? (idx_wide - (ID_W+1)'(NREQ)) : idx_wide;
        idx      = idx_wide[ID_W-1:0];
        hit      = !found && bus.req_valid[idx];
        grant_s[idx] = grant_s[idx] | hit;
        winner_s = hit ? idx : winner_s;
        found    = found | hit;
      end
    end else begin
      grant_s  = '0;
      winner_s = '0;
    end
  end

  assign accept_s      = |grant_s;
  assign bus.req_ready = grant_s;

  // Pick the winner's operand and map it into a sin-unit angle.
  always_comb begin
    sel_angle_s = bus.req_angle[ANGLE_W*winner_s +: ANGLE_W];
    sel_op_s    = sincos_op_t'(bus.req_op[winner_s]);
`ifdef SINCOS_RANGE_REDUCE_EN
    base_angle_s = reduce_angle(sel_angle_s);
`else
    base_angle_s = sel_angle_s;
`endif
    case (sel_op_s)
      OP_SIN:  mapped_angle_s = base_angle_s;
      OP_COS:  mapped_angle_s = cos_shift(base_angle_s);
      default: mapped_angle_s = base_angle_s;
    endcase
  end

  assign sin_angle_o = accept_s ? mapped_angle_s : '0;
  assign sin_en_o    = en_i;

  // Pointer advances past the winner only when something was accepted.
  always_comb begin
    if (accept_s) begin
      ptr_d = (winner_s == ID_W'(NREQ-1)) ? '0 : (winner_s + ID_W'(1));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Tag for the op entering the sin unit this cycle.
  always_comb begin
    tag_in_s              = '0;
    tag_in_s.valid        = accept_s;
    tag_in_s.id[ID_W-1:0] = winner_s;
  end

  sincos_tag_pipe #(
    .DEPTH(SIN_LATENCY)
  ) u_tag_pipe (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (en_i),
    .tag_i      (tag_in_s),
    .tag_o      (tag_last_s),
    .any_valid_o(tag_busy_s)
  );

  // Response capture: the sin result is valid exactly when the last tag stage is.
  always_comb begin
    if (en_i && tag_last_s.valid) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = tag_last_s.id[ID_W-1:0];
      rsp_data_d  = sin_result_i;
    end else begin
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
    end
  end

  // Response registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy_o        = tag_busy_s | rsp_valid_q;

`ifndef SINCOS_RANGE_REDUCE_EN
  sincos_arbiter_chk u_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .accept_i(accept_s),
    .angle_i (sel_angle_s)
  );
`endif

endmodule

// File: tb/tb_sincos_arbiter.sv
// Scoreboard bench for sincos_arbiter: directed requests push hand-computed
// {id, data} expectations; a monitor pops and compares on every rsp_valid,
// including the enabled-cycle latency. A behavioural sin unit with
// SIN_LATENCY en-gated stages stands in for the real one.
module tb_sincos_arbiter;
  import sincos_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic sin_en;
  logic signed [26:0] sin_angle;
  logic signed [26:0] sin_result;
  logic busy;

  sincos_arbiter_if #(.NREQ(NREQ)) bus ();

  sincos_arbiter #(
    .NREQ(NREQ),
    .SIN_LATENCY(LAT)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .en_i        (en),
    .bus         (bus.slave),
    .sin_en_o    (sin_en),
    .sin_angle_o (sin_angle),
    .sin_result_i(sin_result),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural sin unit: round(256*sin(a/256)), LAT en-gated stages.
  function automatic logic signed [26:0] sin_model(input logic signed [26:0] a);
    real r;
    r = $sin($itor(a) / 256.0) * 256.0;
    return 27'($rtoi(r >= 0.0 ? r + 0.5 : r - 0.5));
  endfunction

  logic signed [26:0] sp [LAT];
  always @(posedge clk) begin
    if (sin_en) begin
      for (int i = LAT - 1; i > 0; i--) sp[i] <= sp[i-1];
      sp[0] <= sin_model(sin_angle);
    end
  end
  assign sin_result = sp[LAT-1];

  typedef struct {
    int id;
    int data;
    int ecnt;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int ecnt = 0;      // enabled, non-reset clock edges seen so far
  int ang[NREQ];

  task automatic chk(input string name, input bit ok, input longint act, input longint expv);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every response.
  always @(posedge clk) begin
    bit   en_s;
    bit   rst_s;
    exp_t e;
    int   diff;
    en_s  = en;
    rst_s = reset;
    if (en_s && !rst_s) ecnt++;
    #1;
    if (!rst_s && !en_s)
      chk("rsp_low_while_en0", bus.rsp_valid == 1'b0, bus.rsp_valid, 0);
    if (bus.rsp_valid) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 1'b0, bus.rsp_id, -1);
      end else begin
        e = q.pop_front();
        diff = int'(bus.rsp_data) - e.data;
        chk("rsp_id", int'(bus.rsp_id) == e.id, bus.rsp_id, e.id);
        chk("rsp_data", (diff <= 2) && (diff >= -2), bus.rsp_data, e.data);
        chk("rsp_latency", (ecnt - e.ecnt) == LAT + 1, ecnt - e.ecnt, LAT + 1);
      end
    end
  end

  // One stimulus cycle: drive at negedge, check grant and issued angle, push expectation.
  task automatic drive(input bit en_v, input logic [3:0] v, input logic [3:0] op,
                       input logic [3:0] exp_rdy, input int exp_ang, input int exp_data);
    exp_t e;
    @(negedge clk);
    en = en_v;
    bus.req_valid = v;
    bus.req_op = op;
    for (int i = 0; i < NREQ; i++) bus.req_angle[27*i +: 27] = 27'(ang[i]);
    #1;
    chk("req_ready", bus.req_ready == exp_rdy, bus.req_ready, exp_rdy);
    chk("sin_angle", int'(sin_angle) == exp_ang, sin_angle, exp_ang);
    if (exp_rdy != 4'b0000) begin
      e.id = 0;
      for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) e.id = i;
      e.data = exp_data;
      e.ecnt = ecnt;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
  endtask

  // Wait (bounded) for all expected responses, then check busy drops.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      idle();
      n++;
    end
    chk({name, "_drained"}, q.size() == 0, q.size(), 0);
    idle();
    chk({name, "_busy_low"}, busy == 1'b0, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) ang[i] = 0;
    bus.req_valid = 4'b1111;
    bus.req_op    = 4'b0000;
    bus.req_angle = '0;

    // 1: reset held with all requests valid
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("reset_req_ready", bus.req_ready == 4'b0000, bus.req_ready, 0);
      chk("reset_rsp_valid", bus.rsp_valid == 1'b0, bus.rsp_valid, 0);
      chk("reset_busy", busy == 1'b0, busy, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    en = 1'b1;
    bus.req_valid = 4'b0000;

    // 2: single SIN on req0, angle 0
    ang[0] = 0;
    drive(1'b1, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    idle();
    chk("busy_inflight", busy == 1'b1, busy, 1);
    drain("t2");

    // 3: COS on req2 angle 0, then COS on req3 angle 700
    ang[2] = 0;
    drive(1'b1, 4'b0100, 4'b0100, 4'b0100, 402, 256);
    ang[3] = 700;
    drive(1'b1, 4'b1000, 4'b1000, 4'b1000, -506, -235);
    drain("t3");

    // 4: all four requesters valid for 12 cycles
    ang[0] = 0; ang[1] = 201; ang[2] = 0; ang[3] = -201;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'b1111, 4'b0100, 4'b0001, 0, 0);
      drive(1'b1, 4'b1111, 4'b0100, 4'b0010, 201, 181);
      drive(1'b1, 4'b1111, 4'b0100, 4'b0100, 402, 256);
      drive(1'b1, 4'b1111, 4'b0100, 4'b1000, -201, -181);
    end
    drain("t4");

    // 5: two ops in flight, then en low for 3 cycles
    ang[1] = 402; ang[2] = 201;
    drive(1'b1, 4'b0010, 4'b0000, 4'b0010, 402, 256);
    drive(1'b1, 4'b0100, 4'b0000, 4'b0100, 201, 181);
    for (int c = 0; c < 3; c++) drive(1'b0, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    drain("t5");

    // 6: reset with three ops in flight drops them
    for (int i = 0; i < NREQ; i++) ang[i] = 0;
    drive(1'b1, 4'b1000, 4'b0000, 4'b1000, 0, 0);
    drive(1'b1, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    drive(1'b1, 4'b0010, 4'b0000, 4'b0010, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = 4'b0000;
    q.delete();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("midreset_rsp_valid", bus.rsp_valid == 1'b0, bus.rsp_valid, 0);
      chk("midreset_busy", busy == 1'b0, busy, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) idle();
    chk("post_reset_busy", busy == 1'b0, busy, 0);

`ifdef SINCOS_RANGE_REDUCE_EN
    // Range reduction: 1608 -> 0, -1000 -> 608, COS 1206 -> -402 -> 0
    ang[0] = 1608; ang[1] = -1000; ang[2] = 1206;
    drive(1'b1, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    drive(1'b1, 4'b0010, 4'b0000, 4'b0010, 608, 178);
    drive(1'b1, 4'b0100, 4'b0100, 4'b0100, 0, 0);
    drain("t6r");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
